// File: rtl/jpeg_quant_zigzag.sv
// jpeg_quant_zigzag
//   Quantises one 8x8 block of DCT coefficients against the JPEG Q50 luminance
//   table and presents the results in zigzag order.
//   Flow: IDLE -> LOAD_DATA (64 cyc) -> PROCESS_DATA (66 cyc) -> SAVE_DATA (64 cyc) -> DONE.
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   start          level; high = a block is waiting in the write area
//   data_in_addr   word index into the write area during LOAD_DATA, else 0
//   data_in        write-area word at data_in_addr (low COEF_WIDTH bits used)
//   data_out_addr  result index requested by the register bank
//   data_out       sign-extended result[data_out_addr], 0 for addresses >= 64
//   state_out      IDLE=0 LOAD_DATA=1 PROCESS_DATA=2 SAVE_DATA=3 DONE=4
module jpeg_quant_zigzag #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned COEF_WIDTH = 16,
   parameter int unsigned RECIP_FRAC = 16,
   parameter int unsigned N_COEF     = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [7:0]            data_in_addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [7:0]            data_out_addr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [3:0]            state_out
);

   localparam int unsigned PW = COEF_WIDTH + RECIP_FRAC + 1;  // signed product width

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StLoad    = 3'd1,
      StProcess = 3'd2,
      StSave    = 3'd3,
      StDone    = 3'd4
   } state_e;

   // round(2^16 / Q[i]) for the Q50 luminance table, raster order
   localparam logic [15:0] RECIP [64] = '{
      16'd4096, 16'd5958, 16'd6554, 16'd4096, 16'd2731, 16'd1638, 16'd1285, 16'd1074,
      16'd5461, 16'd5461, 16'd4681, 16'd3449, 16'd2521, 16'd1130, 16'd1092, 16'd1192,
      16'd4681, 16'd5041, 16'd4096, 16'd2731, 16'd1638, 16'd1150, 16'd950,  16'd1170,
      16'd4681, 16'd3855, 16'd2979, 16'd2260, 16'd1285, 16'd753,  16'd819,  16'd1057,
      16'd3641, 16'd2979, 16'd1771, 16'd1170, 16'd964,  16'd601,  16'd636,  16'd851,
      16'd2731, 16'd1872, 16'd1192, 16'd1024, 16'd809,  16'd630,  16'd580,  16'd712,
      16'd1337, 16'd1024, 16'd840,  16'd753,  16'd636,  16'd542,  16'd546,  16'd649,
      16'd910,  16'd712,  16'd690,  16'd669,  16'd585,  16'd655,  16'd636,  16'd662
   };

   // Zigzag position -> raster index
   localparam logic [5:0] ZZ [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   state_e state_q, state_d;
   // 7 bits: PROCESS_DATA runs 66 cycles (64 issues + 2 drain)
   logic [6:0] cnt_q, cnt_d;

   logic signed [COEF_WIDTH-1:0] coef_q [64];
   logic signed [COEF_WIDTH-1:0] res_q  [64];

   logic signed [PW-1:0]         prod_q, prod_d;
   logic [5:0]                   pidx_q;
   logic                         pvld_q;

   logic                         load_en, issue_en;
   logic [5:0]                   issue_raster;
   logic [PW-1:0]                mag;
   logic [COEF_WIDTH-1:0]        q_mag;
   logic signed [COEF_WIDTH-1:0] res_d;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (start) state_d = StLoad;
         StLoad:    if (cnt_q == 7'(N_COEF - 1)) state_d = StProcess;
         StProcess: if (cnt_q == 7'(N_COEF + 1)) state_d = StSave;
         StSave:    if (cnt_q == 7'(N_COEF - 1)) state_d = StDone;
         StDone:    if (!start) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
      // Counter restarts at every state change, counts only in the timed states
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q == StLoad || state_q == StProcess || state_q == StSave) begin
         cnt_d = cnt_q + 7'd1;
      end else begin
         cnt_d = '0;
      end
   end

   always_comb begin
      state_out    = {1'b0, state_q};
      load_en      = (state_q == StLoad);
      issue_en     = (state_q == StProcess) && (cnt_q < 7'(N_COEF));
      data_in_addr = load_en ? {2'b00, cnt_q[5:0]} : 8'd0;
   end

   // ----------------------------------------------------------- datapath
   always_comb begin
      issue_raster = ZZ[cnt_q[5:0]];
      prod_d       = $signed(coef_q[issue_raster]) * $signed({1'b0, RECIP[issue_raster]});
      // Round half away from zero: work on the magnitude, then restore the sign
      mag   = prod_q[PW-1] ? PW'(-prod_q) : PW'(prod_q);
      q_mag = COEF_WIDTH'((mag + PW'(1 << (RECIP_FRAC - 1))) >> RECIP_FRAC);
      res_d = prod_q[PW-1] ? -$signed(q_mag) : $signed(q_mag);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) begin
            coef_q[i] <= '0;
            res_q[i]  <= '0;
         end
         prod_q <= '0;
         pidx_q <= '0;
         pvld_q <= 1'b0;
      end else begin
         if (load_en) coef_q[cnt_q[5:0]] <= data_in[COEF_WIDTH-1:0];
         pvld_q <= issue_en;
         if (issue_en) begin
            prod_q <= prod_d;
            pidx_q <= cnt_q[5:0];
         end
         if (pvld_q) res_q[pidx_q] <= res_d;
      end
   end

   always_comb begin
      if (data_out_addr < 8'(N_COEF)) begin
         data_out = {{(DATA_WIDTH - COEF_WIDTH){res_q[data_out_addr[5:0]][COEF_WIDTH-1]}},
                     res_q[data_out_addr[5:0]]};
      end else begin
         data_out = '0;
      end
   end

endmodule
